// File: rtl/md5_wb_rr_arbiter_if.sv
// Bus bundle between the MD5 requesters, the round-robin arbiter and the md5_top slave port.
// The arbiter uses the slave modport; requesters and the core model use the master modport.
interface md5_wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*SW-1:0]         m_sel_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;

  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [SW-1:0]                     s_sel_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/md5_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one MD5 core; the grant is held for a whole cyc tenure
// so a master can load a block, start the core and read the digest uninterrupted.
module md5_wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  md5_wb_rr_arbiter_if.slave     bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [WW-1:0]          wd_cnt_q, wd_cnt_d;

  logic                   own;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   g_we;
  logic [SW-1:0]          g_sel;
  logic [ADDR_WIDTH-1:0]  g_adr;
  logic [DATA_WIDTH-1:0]  g_dat;
  logic                   stb_raw;
  logic                   wd_fire;
  logic                   s_stb;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      v[k] = (idx == IW'(k)) ? 1'b1 : 1'b0;
    end
    return v;
  endfunction

  assign own = (state_q == ST_OWN);

  // Select the granted master's bus fields.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      g_cyc = (gidx_q == IW'(k)) ? bus.m_cyc_i[k] : g_cyc;
      g_stb = (gidx_q == IW'(k)) ? bus.m_stb_i[k] : g_stb;
      g_we  = (gidx_q == IW'(k)) ? bus.m_we_i[k] : g_we;
      g_sel = (gidx_q == IW'(k)) ? bus.m_sel_i[k*SW +: SW] : g_sel;
      g_adr = (gidx_q == IW'(k)) ? bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH] : g_adr;
      g_dat = (gidx_q == IW'(k)) ? bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH] : g_dat;
    end
  end

  // A strobe without cyc is not a beat, so a master dropping cyc mid-beat also kills the strobe.
  assign stb_raw = own & g_cyc & g_stb;
  assign wd_fire = WD_EN & stb_raw & ~bus.s_ack_i & (wd_cnt_q == WD_LAST);
  assign s_stb   = stb_raw & ~wd_fire;

  // Next requester after last_q, searching upward with wrap.
  always_comb begin
    logic hit;
    int   cand;
    hit        = 1'b0;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = (int'(last_q) + off) % NUM_MASTERS;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        hit        = ~pick_found & (k == cand) & bus.m_cyc_i[k];
        pick_idx   = hit ? IW'(k) : pick_idx;
        pick_found = pick_found | hit;
      end
    end
  end

  // Tenure FSM and watchdog next-state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wd_cnt_d = '0;
        if (pick_found) begin
          state_d = ST_OWN;
          gidx_d  = pick_idx;
          grant_d = onehot(pick_idx);
        end else begin
          grant_d = '0;
        end
      end
      ST_OWN: begin
        if (!g_cyc) begin
          state_d  = ST_IDLE;
          last_d   = gidx_q;
          grant_d  = '0;
          wd_cnt_d = '0;
        end else if (!WD_EN || wd_fire || !s_stb || bus.s_ack_i) begin
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        wd_cnt_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= LAST_RST;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Everything toward the core is gated by ownership, so an async reset drops it at once.
  assign bus.s_cyc_o = own & g_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = own & g_we;
  assign bus.s_sel_o = {SW{own}} & g_sel;
  assign bus.s_adr_o = {ADDR_WIDTH{own}} & g_adr;
  assign bus.s_dat_o = {DATA_WIDTH{own}} & g_dat;

  assign bus.m_dat_o = {DATA_WIDTH{own}} & bus.s_dat_i;
  assign bus.m_ack_o = grant_q & {NUM_MASTERS{bus.s_ack_i & s_stb}};
  assign bus.m_err_o = grant_q & {NUM_MASTERS{wd_fire}};

  assign grant_o = grant_q;
  assign busy_o  = own;
endmodule

// File: tb/tb_md5_wb_rr_arbiter.sv
// Self-checking bench for md5_wb_rr_arbiter: round-robin vector table, hand-written corner
// sequences (lock, watchdog, ack/timeout collision, async reset) and a random run against a model.
module tb_md5_wb_rr_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;

  logic         clk;
  logic         rst_ni;
  logic [N-1:0] grant;
  logic         busy;

  md5_wb_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  md5_wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave),
    .grant_o(grant),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] cyc_v, stb_v, we_v;
  logic [31:0]  adr_v [N];
  logic [31:0]  dat_v [N];
  logic [3:0]   sel_v [N];
  logic         ack_in;
  logic [31:0]  sdat_v;

  // reference model state
  int           own_m;
  int           last_m;
  int           wd_m;
  logic [N-1:0] ack_seen;

  typedef struct {
    logic [N-1:0] cyc;
    logic         ack;
    logic [N-1:0] e_grant;
    logic         e_busy;
    logic         e_scyc;
    logic         e_sstb;
    logic [N-1:0] e_ack;
    int           e_src;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.m_cyc_i = cyc_v;
    bus.m_stb_i = stb_v;
    bus.m_we_i  = we_v;
    for (int k = 0; k < N; k++) begin
      bus.m_adr_i[k*32 +: 32] = adr_v[k];
      bus.m_dat_i[k*32 +: 32] = dat_v[k];
      bus.m_sel_i[k*4 +: 4]   = sel_v[k];
    end
    bus.s_ack_i = ack_in;
    bus.s_dat_i = sdat_v;
  endtask

  task automatic clear_in();
    cyc_v  = '0;
    stb_v  = '0;
    we_v   = '0;
    ack_in = 1'b0;
    sdat_v = 32'h0;
    for (int k = 0; k < N; k++) begin
      adr_v[k] = 32'h0;
      dat_v[k] = 32'h0;
      sel_v[k] = 4'h0;
    end
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_in();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    own_m    = -1;
    last_m   = N - 1;
    wd_m     = 0;
    ack_seen = '0;
  endtask

  // Model: evaluates expected outputs for the current cycle, compares, then advances one clock.
  task automatic model_cycle();
    logic [N-1:0] eg, eack, eerr;
    logic         ebusy, ecyc, estb, sraw, fire;
    int           g;
    eg = '0; eack = '0; eerr = '0;
    ebusy = 1'b0; ecyc = 1'b0; estb = 1'b0; sraw = 1'b0; fire = 1'b0;
    g = own_m;
    if (g >= 0) begin
      sraw  = cyc_v[g] & stb_v[g];
      fire  = sraw & ~ack_in & (wd_m == TMO - 1);
      eg    = 3'b001 << g;
      ebusy = 1'b1;
      ecyc  = cyc_v[g];
      estb  = sraw & ~fire;
      if (estb && ack_in) eack = eg;
      if (fire) eerr = eg;
    end
    chk("rnd_grant", grant, eg);
    chk("rnd_busy", busy, ebusy);
    chk("rnd_s_cyc", bus.s_cyc_o, ecyc);
    chk("rnd_s_stb", bus.s_stb_o, estb);
    chk("rnd_m_ack", bus.m_ack_o, eack);
    chk("rnd_m_err", bus.m_err_o, eerr);
    if (g >= 0) begin
      chk("rnd_s_we", bus.s_we_o, we_v[g]);
      chk("rnd_s_sel", bus.s_sel_o, sel_v[g]);
      chk("rnd_s_adr", bus.s_adr_o, adr_v[g]);
      chk("rnd_s_dat", bus.s_dat_o, dat_v[g]);
      chk("rnd_m_dat", bus.m_dat_o, sdat_v);
    end
    ack_seen = eack;
    if (g < 0) begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (last_m + off) % N;
        if (own_m < 0 && cyc_v[c]) own_m = c;
      end
      wd_m = 0;
    end else if (!cyc_v[g]) begin
      last_m = g;
      own_m  = -1;
      wd_m   = 0;
    end else if (estb && !ack_in) begin
      wd_m = wd_m + 1;
    end else begin
      wd_m = 0;
    end
  endtask

  initial begin
    logic [N-1:0] oh;
    int           acks;
    rst_ni = 1'b0;
    clear_in();

    // Reset state while reset is held.
    settle();
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
    chk("rst_s_stb", bus.s_stb_o, 1'b0);
    chk("rst_m_ack", bus.m_ack_o, 3'b000);
    chk("rst_m_err", bus.m_err_o, 3'b000);

    // Round-robin table: all masters request, owner drops cyc right after its one-beat tenure.
    for (int r = 0; r < 6; r++) begin
      oh = 3'b001 << (r % N);
      tbl[3*r]     = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, -1};
      tbl[3*r + 1] = '{3'b111, 1'b1, oh, 1'b1, 1'b1, 1'b1, oh, r % N};
      tbl[3*r + 2] = '{3'b111 & ~oh, 1'b0, oh, 1'b1, 1'b0, 1'b0, 3'b000, r % N};
    end
    do_reset();
    for (int k = 0; k < N; k++) begin
      adr_v[k] = 32'hA000_0000 + 32'(k);
      dat_v[k] = 32'h5500_0000 + 32'(k);
      sel_v[k] = 4'hF;
    end
    we_v = 3'b111;
    for (int i = 0; i < 18; i++) begin
      cyc_v  = tbl[i].cyc;
      stb_v  = tbl[i].cyc;
      ack_in = tbl[i].ack;
      drive();
      settle();
      chk("rr_grant", grant, tbl[i].e_grant);
      chk("rr_busy", busy, tbl[i].e_busy);
      chk("rr_s_cyc", bus.s_cyc_o, tbl[i].e_scyc);
      chk("rr_s_stb", bus.s_stb_o, tbl[i].e_sstb);
      chk("rr_m_ack", bus.m_ack_o, tbl[i].e_ack);
      if (tbl[i].e_src >= 0) chk("rr_s_adr", bus.s_adr_o, adr_v[tbl[i].e_src]);
      tick();
    end

    // Single master write with ack on the second strobe cycle.
    do_reset();
    cyc_v = 3'b001; stb_v = 3'b001; we_v = 3'b001;
    adr_v[0] = 32'h10; dat_v[0] = 32'hDEADBEEF; sel_v[0] = 4'hF;
    drive();
    settle();
    chk("wr_grant_idle", grant, 3'b000);
    tick();
    acks = 0;
    settle();
    chk("wr_grant", grant, 3'b001);
    chk("wr_s_stb", bus.s_stb_o, 1'b1);
    chk("wr_s_adr", bus.s_adr_o, 32'h10);
    chk("wr_s_dat", bus.s_dat_o, 32'hDEADBEEF);
    chk("wr_s_we", bus.s_we_o, 1'b1);
    acks += int'(bus.m_ack_o[0]);
    tick();
    ack_in = 1'b1; drive();
    settle();
    chk("wr_m_ack", bus.m_ack_o, 3'b001);
    acks += int'(bus.m_ack_o[0]);
    tick();
    cyc_v = 3'b000; stb_v = 3'b000; ack_in = 1'b0; drive();
    settle();
    chk("wr_s_cyc_drop", bus.s_cyc_o, 1'b0);
    acks += int'(bus.m_ack_o[0]);
    tick();
    settle();
    chk("wr_grant_end", grant, 3'b000);
    chk("wr_busy_end", busy, 1'b0);
    chk("wr_ack_count", 64'(acks), 64'd1);

    // Lock: m0 16-beat burst, m1 requests from beat 3 and must wait one idle cycle after m0.
    do_reset();
    cyc_v = 3'b001; stb_v = 3'b001; we_v = 3'b011;
    adr_v[1] = 32'hBAD0_0000; dat_v[1] = 32'h1111_1111; sel_v[1] = 4'h3;
    drive();
    tick();
    acks = 0;
    for (int b = 0; b < 16; b++) begin
      adr_v[0] = 32'h1000 + 32'(4 * b);
      dat_v[0] = 32'(b);
      ack_in = 1'b1;
      if (b >= 3) begin
        cyc_v[1] = 1'b1;
        stb_v[1] = 1'b1;
      end
      drive();
      settle();
      chk("lock_s_adr", bus.s_adr_o, 32'h1000 + 32'(4 * b));
      chk("lock_grant", grant, 3'b001);
      acks += int'(bus.m_ack_o[0]);
      tick();
    end
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0; ack_in = 1'b0; drive();
    settle();
    chk("lock_drop_s_cyc", bus.s_cyc_o, 1'b0);
    chk("lock_drop_grant", grant, 3'b001);
    tick();
    settle();
    chk("lock_idle_grant", grant, 3'b000);
    chk("lock_idle_busy", busy, 1'b0);
    tick();
    settle();
    chk("lock_m1_grant", grant, 3'b010);
    chk("lock_m1_adr", bus.s_adr_o, 32'hBAD0_0000);
    chk("lock_ack_count", 64'(acks), 64'd16);

    // Watchdog: no ack ever; err every 8th strobe cycle with the strobe suppressed.
    do_reset();
    cyc_v = 3'b001; stb_v = 3'b001; drive();
    tick();
    for (int i = 1; i <= 3 * TMO; i++) begin
      settle();
      chk("wd_m_err", bus.m_err_o, (i % TMO == 0) ? 3'b001 : 3'b000);
      chk("wd_s_stb", bus.s_stb_o, (i % TMO == 0) ? 1'b0 : 1'b1);
      chk("wd_grant", grant, 3'b001);
      tick();
    end

    // Ack arriving on the timeout cycle wins.
    do_reset();
    cyc_v = 3'b001; stb_v = 3'b001; drive();
    tick();
    for (int i = 1; i <= TMO; i++) begin
      ack_in = (i == TMO);
      drive();
      settle();
      chk("col_m_ack", bus.m_ack_o, (i == TMO) ? 3'b001 : 3'b000);
      chk("col_m_err", bus.m_err_o, 3'b000);
      tick();
    end

    // Async reset mid-burst of m1 (after an m0 tenure moved last_grant to 0).
    do_reset();
    cyc_v = 3'b001; stb_v = 3'b001; ack_in = 1'b1; drive();
    tick();
    tick();
    cyc_v = 3'b000; stb_v = 3'b000; ack_in = 1'b0; drive();
    tick();
    tick();
    cyc_v = 3'b010; stb_v = 3'b010; ack_in = 1'b1; drive();
    tick();
    for (int b = 1; b <= 5; b++) begin
      settle();
      if (b == 1) chk("ar_m1_grant", grant, 3'b010);
      if (b < 5) tick();
    end
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ar_grant", grant, 3'b000);
    chk("ar_busy", busy, 1'b0);
    chk("ar_s_cyc", bus.s_cyc_o, 1'b0);
    chk("ar_s_stb", bus.s_stb_o, 1'b0);
    chk("ar_m_ack", bus.m_ack_o, 3'b000);
    cyc_v = 3'b011; stb_v = 3'b011; ack_in = 1'b0; drive();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    settle();
    chk("ar_post_idle", grant, 3'b000);
    tick();
    settle();
    chk("ar_post_m0_first", grant, 3'b001);
    tick();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!cyc_v[k]) begin
          if ($urandom_range(99, 0) < 25) begin
            cyc_v[k] = 1'b1;
            stb_v[k] = 1'($urandom_range(1, 0));
            we_v[k]  = 1'($urandom_range(1, 0));
            adr_v[k] = $urandom;
            dat_v[k] = $urandom;
            sel_v[k] = 4'($urandom_range(15, 0));
          end else begin
            stb_v[k] = 1'b0;
          end
        end else if ($urandom_range(99, 0) < 8) begin
          cyc_v[k] = 1'b0;
          stb_v[k] = 1'b0;
        end else if (ack_seen[k]) begin
          stb_v[k] = 1'($urandom_range(1, 0));
          adr_v[k] = $urandom;
          dat_v[k] = $urandom;
        end else if ($urandom_range(99, 0) < 20) begin
          stb_v[k] = ~stb_v[k];
        end
      end
      ack_in = ($urandom_range(99, 0) < ((c < 2000) ? 40 : 8));
      sdat_v = $urandom;
      drive();
      settle();
      model_cycle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
